addsub_seq: RTL and testbench
=============================

# addsub_seq

Byte-serial multi-byte add/subtract sequencer that sits directly upstream of the 8-bit add/sub datapath and drives it. It accepts one wide operand pair per transaction, feeds it through an internal 8-bit add/sub slice one byte per cycle (LSB first), and chains carry or borrow between bytes. It then presents the assembled wide result with signed-overflow and carry/borrow flags on a valid/ready output.

## Interface
- BYTES, 4, operand width in bytes (≥1); data width W = 8*BYTES
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept operands
- op  in  1  0 = add (x + y), 1 = subtract (x − y); sampled on accept
- x  in  W  first operand, two's complement
- y  in  W  second operand, two's complement
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- r  out  W  result
- of  out  1  signed overflow of the full-width operation
- co  out  1  add: unsigned carry out; subtract: borrow out (1 when x < y unsigned)

## Operation
- States: IDLE, RUN, DONE (enum in package).
- IDLE: in_ready=1. When in_valid && in_ready, latch x, y, op; byte index idx=0; carry register c=op (subtract is x + ~y + 1); go to RUN.
- RUN: each cycle, process byte idx: sum = x[idx] + (y[idx] ^ {8{op}}) + c. Write the low 8 bits into r byte idx and the carry out into c; idx++. After idx = BYTES−1, go to DONE.
- On the last byte, of = (xa[7] == yb[7]) && (sum[7] != xa[7]), where xa and yb are the slice inputs after y inversion. co = c_final ^ op.
- DONE: out_valid=1; r, of, co held stable. On out_ready, go to IDLE.
- in_ready=0 in RUN and DONE. in_valid is ignored outside IDLE.
- Result bytes not yet processed read 0 during RUN. Outputs are only meaningful when out_valid=1.
- BYTES=1 is legal: RUN lasts one cycle.

## Timing
- Reset (async assert, sync release): state=IDLE, in_ready=1, out_valid=0, r=0, of=0, co=0, idx=0, c=0.
- Accept at edge T → RUN for edges T+1..T+BYTES → out_valid=1 after edge T+BYTES (latency BYTES+1 cycles from accept edge to result handshake opportunity).
- Output handshake at edge U → out_valid=0 and in_ready=1 after edge U. Earliest next accept is at edge U+1. Peak throughput is one transaction per BYTES+2 cycles.
- out_ready held low: DONE persists indefinitely; outputs do not change.
- out_ready high before DONE has no effect.
- rst_n asserted mid-RUN or mid-DONE: transaction discarded, all outputs return to reset values immediately.

## Configuration
- ADDSUB_SEQ_SAT_EN defined: in DONE, if of=1, r is clamped. It becomes {1'b0,{W-1{1'b1}}} when the true result is positive overflow (x sign = 0) and {1'b1,{W-1{1'b0}}} when it is negative (x sign = 1). of and co are still reported unchanged.
- Not defined: r is the wrapped two's-complement result. No clamp logic is present.

## Structure
- Package addsub_pkg: state enum (IDLE, RUN, DONE), BYTE_W=8 constant, default BYTES.
- Sub-module addsub_byte: combinational 8-bit slice with inputs a[7:0], b[7:0], op, ci and outputs s[7:0], co, ovf. It applies the y inversion internally. It is instanced once and time-multiplexed by idx.
- Top holds the FSM, the idx counter (width $clog2(BYTES)+1), the operand/result registers and the carry register.

## Test plan
- BYTES=4, add 0x000000FF + 0x00000001 → r=0x00000100, co=0, of=0. out_valid rises exactly 4 cycles after the accept edge.
- Subtract 0x00000000 − 0x00000001 → r=0xFFFFFFFF, co=1, of=0. Subtract 0x00000005 − 0x00000003 → r=0x00000002, co=0.
- Add 0x7FFFFFFF + 0x00000001 → of=1, r=0x80000000 (SAT_EN: 0x7FFFFFFF). Subtract 0x80000000 − 0x00000001 → of=1, r=0x7FFFFFFF (SAT_EN: 0x80000000).
- Back-pressure: hold out_ready=0 for 5 cycles in DONE → r/of/co stable, in_ready=0, and a new in_valid is not accepted. After release, the next transaction is accepted one cycle later.
- Pull rst_n low two cycles into RUN → out_valid=0, in_ready=1 and r=0 immediately. The following transaction 0x01020304 + 0x10203040 → r=0x11223344.
- BYTES=1 build: add 0x7F + 0x01 → r=0x80, of=1, co=0. Latency is 1 cycle to out_valid.

Source files
------------

// File: rtl/addsub_pkg.sv
// rtl/addsub_pkg.sv - shared types and constants for the byte-serial add/sub sequencer
package addsub_pkg;

  localparam int BYTE_W        = 8;
  localparam int DEFAULT_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/addsub_byte.sv
// rtl/addsub_byte.sv - combinational 8-bit add/sub slice with carry chain and signed overflow
module addsub_byte
  import addsub_pkg::*;
(
  input  logic [BYTE_W-1:0] a_i,
  input  logic [BYTE_W-1:0] b_i,
  input  logic              op_i,
  input  logic              ci_i,
  output logic [BYTE_W-1:0] s_o,
  output logic              co_o,
  output logic              ovf_o
);

  logic [BYTE_W-1:0] b_x;
  logic [BYTE_W:0]   sum;

  // Subtract is x + ~y + carry-in; the sequencer seeds the first carry with op.
  always_comb begin
    b_x   = b_i ^ {BYTE_W{op_i}};
    sum   = {1'b0, a_i} + {1'b0, b_x} + {{BYTE_W{1'b0}}, ci_i};
    s_o   = sum[BYTE_W-1:0];
    co_o  = sum[BYTE_W];
    ovf_o = (a_i[BYTE_W-1] == b_x[BYTE_W-1]) && (sum[BYTE_W-1] != a_i[BYTE_W-1]);
  end

endmodule

// File: rtl/addsub_seq.sv
// rtl/addsub_seq.sv - byte-serial multi-byte add/sub sequencer (optional clamp: ADDSUB_SEQ_SAT_EN)
module addsub_seq
  import addsub_pkg::*;
#(
  parameter int BYTES = DEFAULT_BYTES
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic                  op_i,
  input  logic [BYTE_W*BYTES-1:0] x_i,
  input  logic [BYTE_W*BYTES-1:0] y_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [BYTE_W*BYTES-1:0] r_o,
  output logic                  of_o,
  output logic                  co_o
);

  localparam int W  = BYTE_W * BYTES;
  localparam int IW = $clog2(BYTES) + 1;
  localparam int SW = (BYTES > 1) ? $clog2(BYTES) : 1;

  state_e                         state_q;
  logic [IW-1:0]                  idx_q;
  logic                           c_q;
  logic                           op_q;
  logic [BYTES-1:0][BYTE_W-1:0]   x_q;
  logic [BYTES-1:0][BYTE_W-1:0]   y_q;
  logic [BYTES-1:0][BYTE_W-1:0]   r_q;
  logic [BYTES-1:0][BYTE_W-1:0]   r_d;
  logic                           in_ready_q;
  logic                           out_valid_q;
  logic                           of_q;
  logic                           co_q;

  logic [SW-1:0]                  sel;
  logic                           last;
  logic [BYTE_W-1:0]              slice_s;
  logic                           slice_co;
  logic                           slice_ovf;

  assign sel  = idx_q[SW-1:0];
  assign last = (idx_q == IW'(BYTES - 1));

  addsub_byte u_slice (
    .a_i   (x_q[sel]),
    .b_i   (y_q[sel]),
    .op_i  (op_q),
    .ci_i  (c_q),
    .s_o   (slice_s),
    .co_o  (slice_co),
    .ovf_o (slice_ovf)
  );

  // Merge the current slice byte into the result; optionally clamp on the final byte.
  always_comb begin
    r_d      = r_q;
    r_d[sel] = slice_s;
`ifdef ADDSUB_SEQ_SAT_EN
    if (last && slice_ovf) begin
      r_d = x_q[BYTES-1][BYTE_W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
`endif
  end

  // Sequencer FSM: accept operands, walk bytes LSB first, then hold the result until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      c_q         <= 1'b0;
      op_q        <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      r_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      of_q        <= 1'b0;
      co_q        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid_i && in_ready_q) begin
            x_q        <= x_i;
            y_q        <= y_i;
            op_q       <= op_i;
            c_q        <= op_i;
            idx_q      <= '0;
            r_q        <= '0;
            of_q       <= 1'b0;
            co_q       <= 1'b0;
            in_ready_q <= 1'b0;
            state_q    <= RUN;
          end
        end
        RUN: begin
          r_q   <= r_d;
          c_q   <= slice_co;
          idx_q <= idx_q + 1'b1;
          if (last) begin
            of_q        <= slice_ovf;
            co_q        <= slice_co ^ op_q;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign r_o         = r_q;
  assign of_o        = of_q;
  assign co_o        = co_q;

endmodule

// File: tb/tb_addsub_seq.sv
// tb/tb_addsub_seq.sv - randomized and directed self-checking bench for addsub_seq
module tb_addsub_seq;

  localparam int BYTES = 4;
  localparam int W     = 8 * BYTES;
  localparam int BOUND = 4 * BYTES + 10;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic         op;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] r;
  logic         of;
  logic         co;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  addsub_seq #(.BYTES(BYTES)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .op_i        (op),
    .x_i         (x),
    .y_i         (y),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .r_o         (r),
    .of_o        (of),
    .co_o        (co)
  );

  // Reference: whole-word arithmetic on W+1 bits.
  task automatic model(input logic opv, input logic [W-1:0] xv, input logic [W-1:0] yv,
                       output logic [W-1:0] rv, output logic ofv, output logic cov);
    logic [W:0] full;
    if (!opv) begin
      full = {1'b0, xv} + {1'b0, yv};
      cov  = full[W];
      ofv  = (xv[W-1] == yv[W-1]) && (full[W-1] != xv[W-1]);
    end else begin
      full = {1'b0, xv} - {1'b0, yv};
      cov  = (xv < yv);
      ofv  = (xv[W-1] != yv[W-1]) && (full[W-1] != xv[W-1]);
    end
    rv = full[W-1:0];
`ifdef ADDSUB_SEQ_SAT_EN
    if (ofv) rv = xv[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
  endtask

  // Drives one transaction from IDLE and returns what was observed; no checking here.
  task automatic run_txn(input logic opv, input logic [W-1:0] xv, input logic [W-1:0] yv,
                         output logic [W-1:0] rv, output logic ofv, output logic cov,
                         output int lat, output logic acc_ok);
    in_valid = 1'b1; op = opv; x = xv; y = yv;
    acc_ok = in_ready;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0; x = '0; y = '0;
    lat = 0;
    while (!out_valid && lat < BOUND) begin
      @(negedge clk); lat++;
    end
    rv = r; ofv = of; cov = co;
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = 1'b0; x = '0; y = '0;
    @(negedge clk); @(negedge clk);
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    tests_run++; if (r !== '0) begin tests_failed++; $display("FAIL reset_r got %h want 0", r); end
    tests_run++; if ({of, co} !== 2'b00) begin tests_failed++; $display("FAIL reset_flags got %b want 00", {of, co}); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic         t_op [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [W-1:0] t_x  [5] = '{32'h000000FF, 32'h00000000, 32'h00000005, 32'h7FFFFFFF, 32'h80000000};
    logic [W-1:0] t_y  [5] = '{32'h00000001, 32'h00000001, 32'h00000003, 32'h00000001, 32'h00000001};
`ifdef ADDSUB_SEQ_SAT_EN
    logic [W-1:0] t_r  [5] = '{32'h00000100, 32'hFFFFFFFF, 32'h00000002, 32'h7FFFFFFF, 32'h80000000};
`else
    logic [W-1:0] t_r  [5] = '{32'h00000100, 32'hFFFFFFFF, 32'h00000002, 32'h80000000, 32'h7FFFFFFF};
`endif
    logic         t_of [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic         t_co [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [W-1:0] rv;
    logic         ofv, cov, acc;
    int           lat;
    for (int i = 0; i < 5; i++) begin
      run_txn(t_op[i], t_x[i], t_y[i], rv, ofv, cov, lat, acc);
      tests_run++; if (acc !== 1'b1) begin tests_failed++; $display("FAIL dir%0d_accept in_ready %b want 1", i, acc); end
      tests_run++; if (lat != BYTES) begin tests_failed++; $display("FAIL dir%0d_latency got %0d want %0d", i, lat, BYTES); end
      tests_run++; if (rv !== t_r[i]) begin tests_failed++; $display("FAIL dir%0d_r got %h want %h", i, rv, t_r[i]); end
      tests_run++; if (ofv !== t_of[i]) begin tests_failed++; $display("FAIL dir%0d_of got %b want %b", i, ofv, t_of[i]); end
      tests_run++; if (cov !== t_co[i]) begin tests_failed++; $display("FAIL dir%0d_co got %b want %b", i, cov, t_co[i]); end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] xv, yv, rv, er;
    logic         opv, ofv, cov, eof, eco, acc;
    int           lat;
    for (int i = 0; i < 40; i++) begin
      opv = 1'($urandom_range(0, 1));
      xv  = $urandom;
      yv  = $urandom;
      if (i % 5 == 1) yv = xv;
      if (i % 5 == 2) xv = {1'b1, 31'($urandom) & 31'h0000FFFF};
      if (i % 5 == 3) yv = {1'b0, 31'h7FFFFF00 | 31'($urandom_range(0, 255))};
      model(opv, xv, yv, er, eof, eco);
      run_txn(opv, xv, yv, rv, ofv, cov, lat, acc);
      tests_run++;
      if (rv !== er || ofv !== eof || cov !== eco || lat != BYTES || acc !== 1'b1) begin
        tests_failed++;
        $display("FAIL rand%0d op=%b x=%h y=%h got r=%h of=%b co=%b lat=%0d want r=%h of=%b co=%b lat=%0d",
                 i, opv, xv, yv, rv, ofv, cov, lat, er, eof, eco, BYTES);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] er, er2;
    logic         eof, eco, eof2, eco2;
    int           n;
    model(1'b1, 32'h12345678, 32'h9ABCDEF0, er, eof, eco);
    in_valid = 1'b1; op = 1'b1; x = 32'h12345678; y = 32'h9ABCDEF0;
    @(posedge clk); @(negedge clk);
    op = 1'b0; x = 32'hDEADBEEF; y = 32'h01010101;
    model(1'b0, 32'hDEADBEEF, 32'h01010101, er2, eof2, eco2);
    n = 0;
    while (!out_valid && n < BOUND) begin @(negedge clk); n++; end
    for (int c = 0; c < 5; c++) begin
      tests_run++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || r !== er || of !== eof || co !== eco) begin
        tests_failed++;
        $display("FAIL bp_hold%0d got v=%b rdy=%b r=%h of=%b co=%b want v=1 rdy=0 r=%h of=%b co=%b",
                 c, out_valid, in_ready, r, of, co, er, eof, eco);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      tests_failed++; $display("FAIL bp_release got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
    end
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_next_accept in_ready %b want 0", in_ready); end
    n = 0;
    while (!out_valid && n < BOUND) begin @(negedge clk); n++; end
    tests_run++;
    if (r !== er2 || of !== eof2 || co !== eco2 || n != BYTES) begin
      tests_failed++;
      $display("FAIL bp_next_result got r=%h of=%b co=%b lat=%0d want r=%h of=%b co=%b lat=%0d",
               r, of, co, n, er2, eof2, eco2, BYTES);
    end
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset_midrun();
    logic [W-1:0] rv, partial;
    logic         ofv, cov, acc;
    int           lat;
    partial = (32'h11111111 + 32'h22222222) & 32'h0000FFFF;
    in_valid = 1'b1; op = 1'b0; x = 32'h11111111; y = 32'h22222222;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    tests_run++; if (r !== partial) begin tests_failed++; $display("FAIL midrun_partial_r got %h want %h", r, partial); end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || r !== '0 || of !== 1'b0 || co !== 1'b0) begin
      tests_failed++;
      $display("FAIL midrun_reset got v=%b rdy=%b r=%h of=%b co=%b want v=0 rdy=1 r=0 of=0 co=0",
               out_valid, in_ready, r, of, co);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_txn(1'b0, 32'h01020304, 32'h10203040, rv, ofv, cov, lat, acc);
    tests_run++;
    if (rv !== 32'h11223344 || ofv !== 1'b0 || cov !== 1'b0 || lat != BYTES || acc !== 1'b1) begin
      tests_failed++;
      $display("FAIL midrun_after got r=%h of=%b co=%b lat=%0d want r=11223344 of=0 co=0 lat=%0d",
               rv, ofv, cov, lat, BYTES);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] exp_r[$];
    logic         exp_of[$];
    logic         exp_co[$];
    logic [W-1:0] er;
    logic         eof, eco, just_acc;
    int           last_acc, n_acc;
    last_acc = -1; n_acc = 0; just_acc = 1'b0;
    out_ready = 1'b1; in_valid = 1'b1;
    op = 1'($urandom_range(0, 1)); x = $urandom; y = $urandom;
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (out_valid) begin
        tests_run++;
        if (exp_r.size() == 0) begin
          tests_failed++; $display("FAIL b2b_unexpected_result r=%h", r);
        end else begin
          er = exp_r.pop_front(); eof = exp_of.pop_front(); eco = exp_co.pop_front();
          if (r !== er || of !== eof || co !== eco) begin
            tests_failed++;
            $display("FAIL b2b_result got r=%h of=%b co=%b want r=%h of=%b co=%b", r, of, co, er, eof, eco);
          end
        end
      end
      if (just_acc) begin
        op = 1'($urandom_range(0, 1)); x = $urandom; y = $urandom;
      end
      just_acc = in_ready;
      if (in_ready) begin
        model(op, x, y, er, eof, eco);
        exp_r.push_back(er); exp_of.push_back(eof); exp_co.push_back(eco);
        if (last_acc >= 0) begin
          tests_run++;
          if (cyc - last_acc != BYTES + 2) begin
            tests_failed++; $display("FAIL b2b_period got %0d want %0d", cyc - last_acc, BYTES + 2);
          end
        end
        last_acc = cyc; n_acc++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    for (int cyc = 0; cyc < BOUND && exp_r.size() > 0; cyc++) begin
      if (out_valid) begin
        er = exp_r.pop_front(); eof = exp_of.pop_front(); eco = exp_co.pop_front();
        tests_run++;
        if (r !== er || of !== eof || co !== eco) begin
          tests_failed++;
          $display("FAIL b2b_drain got r=%h of=%b co=%b want r=%h of=%b co=%b", r, of, co, er, eof, eco);
        end
      end
      @(negedge clk);
    end
    tests_run++;
    if (exp_r.size() != 0 || n_acc < 8) begin
      tests_failed++; $display("FAIL b2b_count pending=%0d accepted=%0d want pending=0 accepted>=8", exp_r.size(), n_acc);
    end
    out_ready = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_midrun();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
